// File: rtl/jtkunio_bank_responder.sv
// Block-RAM backed responder for the 4-bank ROM request/ack interface plus download writes.
// Define JTKUNIO_REFRESH_EN to insert periodic 4-cycle refresh stalls between transactions.
module jtkunio_bank_responder #(
    parameter int unsigned AW      = 16,
    parameter int unsigned BURST   = 2,
    parameter int unsigned LAT     = 3,
    parameter int unsigned REF_PER = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    output logic        prog_ack,
    output logic        prog_rdy
);

    localparam int unsigned MW = AW + 2;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWait    = 3'd1;
    localparam logic [2:0] StBurst   = 3'd2;
    localparam logic [2:0] StWrdone  = 3'd3;
`ifdef JTKUNIO_REFRESH_EN
    localparam logic [2:0] StRefresh = 3'd4;
`endif

    logic [15:0]   mem [0:(2**MW)-1];
    logic [2:0]    st_q, st_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    bank_q, bank_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    ack_d, dst_d, dok_d, rdy_d;
    logic          prog_ack_d, prog_rdy_d;
    logic          rd_en, wr_en;
    logic          gnt_vld;
    logic [1:0]    gnt;
    logic [AW-1:0] gnt_addr;
    logic [MW-1:0] wr_addr;

    assign wr_addr = {prog_ba, prog_addr[AW-1:0]};

`ifdef JTKUNIO_REFRESH_EN
    localparam int unsigned RW = (REF_PER > 1) ? $clog2(REF_PER) : 1;
    logic [RW-1:0] ref_cnt_q;
    logic          ref_pend_q;
    logic          ref_hit;

    assign ref_hit = (ref_cnt_q == RW'(REF_PER - 1));

    // Pending flag survives until the FSM is next idle, so bursts are never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_hit ? '0 : ref_cnt_q + RW'(1);
            if (ref_hit) begin
                ref_pend_q <= 1'b1;
            end else if (st_q == StIdle) begin
                ref_pend_q <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_ref;
    assign unused_ref = REF_PER;
`endif

    logic unused_bits;
    assign unused_bits = ^{ba0_addr[21:AW], ba1_addr[21:AW], ba2_addr[21:AW],
                           ba3_addr[21:AW], prog_addr[21:AW]};

    // Round robin: lowest offset from the pointer wins, hence the descending scan.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (ba_rd[ptr_q + 2'(i)]) begin
                gnt_vld = 1'b1;
                gnt     = ptr_q + 2'(i);
            end
        end
        gnt_addr = ba0_addr[AW-1:0];
        case (gnt)
            2'd1:    gnt_addr = ba1_addr[AW-1:0];
            2'd2:    gnt_addr = ba2_addr[AW-1:0];
            2'd3:    gnt_addr = ba3_addr[AW-1:0];
            default: gnt_addr = ba0_addr[AW-1:0];
        endcase
    end

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        ack_d      = 4'd0;
        dst_d      = 4'd0;
        dok_d      = 4'd0;
        rdy_d      = 4'd0;
        prog_ack_d = 1'b0;
        prog_rdy_d = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (st_q)
            StIdle: begin
`ifdef JTKUNIO_REFRESH_EN
                if (ref_pend_q) begin
                    st_d  = StRefresh;
                    cnt_d = 8'd0;
                end else
`endif
                if (prog_we) begin
                    wr_en      = rst_n;
                    prog_ack_d = 1'b1;
                    cnt_d      = 8'd0;
                    st_d       = StWrdone;
                end else if (gnt_vld) begin
                    ack_d[gnt] = 1'b1;
                    bank_d     = gnt;
                    addr_d     = gnt_addr;
                    ptr_d      = gnt + 2'd1;
                    cnt_d      = 8'd0;
                    st_d       = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 8'(LAT - 1)) begin
                    rd_en          = 1'b1;
                    dst_d[bank_q]  = 1'b1;
                    dok_d[bank_q]  = 1'b1;
                    rdy_d[bank_q]  = (BURST == 1);
                    addr_d         = addr_q + AW'(1);
                    cnt_d          = 8'd1;
                    st_d           = StBurst;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StBurst: begin
                // Extra pass with cnt==BURST gives the one idle cycle after rdy.
                if (cnt_q == 8'(BURST)) begin
                    st_d = StIdle;
                end else begin
                    rd_en         = 1'b1;
                    dok_d[bank_q] = 1'b1;
                    rdy_d[bank_q] = (cnt_q == 8'(BURST - 1));
                    addr_d        = addr_q + AW'(1);
                    cnt_d         = cnt_q + 8'd1;
                end
            end
            StWrdone: begin
                if (cnt_q == 8'(LAT - 1)) begin
                    prog_rdy_d = 1'b1;
                    st_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef JTKUNIO_REFRESH_EN
            StRefresh: begin
                if (cnt_q == 8'd3) begin
                    st_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= StIdle;
            cnt_q     <= 8'd0;
            ptr_q     <= 2'd0;
            bank_q    <= 2'd0;
            addr_q    <= '0;
            ba_ack    <= 4'd0;
            ba_dst    <= 4'd0;
            ba_dok    <= 4'd0;
            ba_rdy    <= 4'd0;
            prog_ack  <= 1'b0;
            prog_rdy  <= 1'b0;
            data_read <= 16'd0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            ba_ack   <= ack_d;
            ba_dst   <= dst_d;
            ba_dok   <= dok_d;
            ba_rdy   <= rdy_d;
            prog_ack <= prog_ack_d;
            prog_rdy <= prog_rdy_d;
            if (rd_en) begin
                data_read <= mem[{bank_q, addr_q}];
            end
        end
    end

    // Memory is not reset so downloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!prog_mask[0]) mem[wr_addr][7:0]  <= prog_data[7:0];
            if (!prog_mask[1]) mem[wr_addr][15:8] <= prog_data[15:8];
        end
    end

endmodule

// File: tb/tb_jtkunio_bank_responder.sv
// Scoreboard bench for jtkunio_bank_responder: expected words are queued on ack and
// compared (data, bank, dst/rdy, cycle) as ba_dok is observed.
module tb_jtkunio_bank_responder;

    localparam int LAT   = 3;
    localparam int BURST = 2;
    localparam int GAP   = LAT + BURST + 1;

    typedef struct {
        int          bank;
        logic [15:0] data;
        int          cyc;
        logic        dst;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] baddr [4];
    logic [3:0]  ba_rd;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_ack, prog_rdy;

    exp_t        sb[$];
    logic [15:0] model [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    jtkunio_bank_responder #(
        .AW      (16),
        .BURST   (BURST),
        .LAT     (LAT),
        .REF_PER (512)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ba0_addr  (baddr[0]),
        .ba1_addr  (baddr[1]),
        .ba2_addr  (baddr[2]),
        .ba3_addr  (baddr[3]),
        .ba_rd     (ba_rd),
        .ba_ack    (ba_ack),
        .ba_dst    (ba_dst),
        .ba_dok    (ba_dok),
        .ba_rdy    (ba_rdy),
        .data_read (data_read),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_mask (prog_mask),
        .prog_ba   (prog_ba),
        .prog_we   (prog_we),
        .prog_ack  (prog_ack),
        .prog_rdy  (prog_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int key(input int b, input logic [15:0] a);
        return b * 65536 + int'(a);
    endfunction

    function automatic void model_wr(input int b, input logic [15:0] a, input logic [15:0] d,
                                     input logic [1:0] m);
        logic [15:0] old;
        old = model.exists(key(b, a)) ? model[key(b, a)] : 16'h0;
        model[key(b, a)] = {m[1] ? old[15:8] : d[15:8], m[0] ? old[7:0] : d[7:0]};
    endfunction

    // Scoreboard: push on ack, pop and compare on every data-valid cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (rst_n) begin
            if (ba_ack != 4'd0) begin
                chk("ack_onehot", $countones(ba_ack), 1);
                for (int i = 0; i < 4; i++) begin
                    if (ba_ack[i]) begin
                        for (int k = 0; k < BURST; k++) begin
                            e.bank = i;
                            e.data = model[key(i, baddr[i][15:0] + 16'(k))];
                            e.cyc  = cyc + LAT + k;
                            e.dst  = (k == 0);
                            e.rdy  = (k == BURST - 1);
                            sb.push_back(e);
                        end
                    end
                end
            end
            if (ba_dok != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_dok", 32'(ba_dok), 0);
                end else begin
                    g = sb.pop_front();
                    chk("dok_bank", 32'(ba_dok), 32'd1 << g.bank);
                    chk("data_read", 32'(data_read), 32'(g.data));
                    chk("dst", 32'(ba_dst), g.dst ? (32'd1 << g.bank) : 32'd0);
                    chk("rdy", 32'(ba_rdy), g.rdy ? (32'd1 << g.bank) : 32'd0);
                    chk("data_cycle", cyc, g.cyc);
                end
            end else if ((ba_dst | ba_rdy) != 4'd0) begin
                chk("stray_dst_rdy", 32'(ba_dst | ba_rdy), 0);
            end
        end
    end

    task automatic wait_drain();
        int n;
        repeat (GAP) @(negedge clk);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic prog_write(input int b, input logic [15:0] a, input logic [15:0] d,
                              input logic [1:0] m);
        int n;
        prog_ba   = 2'(b);
        prog_addr = {6'd0, a};
        prog_data = d;
        prog_mask = m;
        prog_we   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prog_ack && n < 50);
        chk("prog_ack_lat", n, 1);
        prog_we = 1'b0;
        model_wr(b, a, d, m);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prog_rdy && n < 50);
        chk("prog_rdy_lat", n, LAT);
    endtask

    task automatic bank_read(input int b, input logic [15:0] a);
        int n;
        baddr[b] = {6'd0, a};
        ba_rd[b] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ba_ack[b] && n < 50);
        chk("ba_ack_lat", n, 1);
        ba_rd[b] = 1'b0;
        wait_drain();
    endtask

    initial begin
        int n, na, c0, pa, pr, ga;
        int abank [5];
        int acyc [5];
        for (int i = 0; i < 4; i++) baddr[i] = 22'd0;
        ba_rd = 4'd0;
        prog_addr = 22'd0;
        prog_data = 16'd0;
        prog_mask = 2'b00;
        prog_ba = 2'd0;
        prog_we = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ba_ack), 0);
        chk("rst_dok", 32'(ba_dok), 0);
        chk("rst_prog", 32'({prog_ack, prog_rdy}), 0);
        chk("rst_data", 32'(data_read), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write then readback, then byte-masked overwrites.
        prog_write(2, 16'h0010, 16'hBEEF, 2'b00);
        prog_write(2, 16'h0011, 16'h0101, 2'b00);
        bank_read(2, 16'h0010);
        prog_write(2, 16'h0010, 16'h1234, 2'b10);
        prog_write(2, 16'h0011, 16'hABCD, 2'b01);
        bank_read(2, 16'h0010);

        // Address wrap at the top of the bank.
        prog_write(1, 16'hFFFF, 16'hAAAA, 2'b00);
        prog_write(1, 16'h0000, 16'h5555, 2'b00);
        bank_read(1, 16'hFFFF);

        // Prepare all banks, then bring the pointer back to 0 with a bank-3 read.
        for (int b = 0; b < 4; b++) begin
            prog_write(b, 16'h0040, 16'h1000 * 16'(b) + 16'h0040, 2'b00);
            prog_write(b, 16'h0041, 16'h2000 * 16'(b) + 16'h0C41, 2'b00);
            baddr[b] = 22'h40;
        end
        bank_read(3, 16'h0040);

        // All four requests held: round robin order and fixed spacing.
        ba_rd = 4'hF;
        n = 0;
        na = 0;
        while (na < 5 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (ba_ack[i] && na < 5) begin
                    abank[na] = i;
                    acyc[na] = cyc;
                    na++;
                end
            end
        end
        ba_rd = 4'd0;
        chk("rr_ack_count", na, 5);
        for (int i = 0; i < na; i++) begin
            chk("rr_order", abank[i], i % 4);
            if (i > 0) chk("rr_gap", acyc[i] - acyc[i-1], GAP);
        end
        wait_drain();

        // Write and read raised together: write wins, read follows prog_rdy.
        prog_ba = 2'd0;
        prog_addr = 22'h40;
        prog_data = 16'h7777;
        prog_mask = 2'b00;
        prog_we = 1'b1;
        baddr[0] = 22'h40;
        ba_rd[0] = 1'b1;
        c0 = cyc;
        pa = -1;
        pr = -1;
        ga = -1;
        n = 0;
        while (ga < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (prog_ack) begin
                pa = cyc;
                prog_we = 1'b0;
                model_wr(0, 16'h0040, 16'h7777, 2'b00);
            end
            if (prog_rdy) pr = cyc;
            if (ba_ack[0]) begin
                ga = cyc;
                ba_rd[0] = 1'b0;
            end
        end
        chk("prio_prog_ack", pa - c0, 1);
        chk("prio_prog_rdy", pr - c0, 1 + LAT);
        chk("prio_ba_ack", ga - c0, 2 + LAT);
        wait_drain();

        // Reset in the middle of a burst, request kept high across it.
        baddr[2] = 22'h10;
        ba_rd[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ba_dst[2] && n < 50);
        chk("pre_rst_dst", 32'(ba_dst[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dok", 32'(ba_dok), 0);
        chk("async_rst_dst", 32'(ba_dst), 0);
        chk("async_rst_data", 32'(data_read), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ba_ack[2] && n < 50);
        chk("post_rst_ack", 32'(ba_ack[2]), 1);
        ba_rd[2] = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
